// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the K=3, rate-1/2 convolutional codec.
package viterbi_pkg;

   localparam int K       = 3;
   localparam int NSTATES = 1 << (K - 1);

   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;

   typedef logic [1:0] sym_t;
   typedef logic [1:0] state_t;

   // Encoder output for state s = {b[n-1], b[n-2]} and input bit u; [1]=G0, [0]=G1.
   function automatic sym_t branch_out(state_t s, logic u);
      logic [2:0] taps;
      taps = {u, s};
      return {^(taps & G0), ^(taps & G1)};
   endfunction

   // Hamming distance between two symbols, 0..2.
   function automatic logic [1:0] hamming(sym_t a, sym_t b);
      sym_t d;
      d = a ^ b;
      return {1'b0, d[1]} + {1'b0, d[0]};
   endfunction

endpackage

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder with a one-cycle registered output.
module conv_encoder_k3
   import viterbi_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic d_in,
   output logic valid,
   output sym_t d_out
);

   state_t shift_state;

   // Shift the new bit in and register its symbol; everything holds while idle except valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_state <= '0;
         d_out       <= '0;
         valid       <= 1'b0;
      end else begin
         valid <= enable;
         if (enable) begin
            d_out       <= branch_out(shift_state, d_in);
            shift_state <= {d_in, shift_state[1]};
         end
      end
   end

endmodule

// File: rtl/viterbi_codec.sv
// Convolutional encoder plus hard-decision register-exchange Viterbi decoder.
module viterbi_codec
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 8
)
(
   input  logic clk,
   input  logic rst,
   input  logic enc_enable_i,
   input  logic enc_d_in,
   output logic enc_valid_o,
   output sym_t enc_d_out,
   input  logic dec_enable,
   input  sym_t dec_d_in,
   output logic dec_d_out
);

   logic [PM_W-1:0]     pm        [NSTATES];
   logic [PM_W-1:0]     pm_next   [NSTATES];
   logic [TB_DEPTH-1:0] surv      [NSTATES];
   logic [TB_DEPTH-1:0] surv_next [NSTATES];
   logic [PM_W-1:0]     min_pm;
   state_t              best;

   conv_encoder_k3 u_encoder (
      .clk    (clk),
      .rst    (rst),
      .enable (enc_enable_i),
      .d_in   (enc_d_in),
      .valid  (enc_valid_o),
      .d_out  (enc_d_out)
   );

   // Smallest current metric and its state; the lowest index wins a tie.
   always_comb begin
      min_pm = pm[0];
      best   = '0;
      for (int i = 1; i < NSTATES; i++) begin
         if (pm[i] < min_pm) begin
            min_pm = pm[i];
            best   = state_t'(i);
         end
      end
   end

   // Add-compare-select per next state; ties go to the predecessor whose low bit is 0.
   always_comb begin
      state_t          ns;
      state_t          p0;
      state_t          p1;
      logic            u;
      logic [PM_W-1:0] c0;
      logic [PM_W-1:0] c1;
      ns = '0;
      p0 = '0;
      p1 = '0;
      u  = 1'b0;
      c0 = '0;
      c1 = '0;
      for (int i = 0; i < NSTATES; i++) begin
         pm_next[i]   = '0;
         surv_next[i] = '0;
      end
      for (int n = 0; n < NSTATES; n++) begin
         ns = state_t'(n);
         u  = ns[1];
         p0 = {ns[0], 1'b0};
         p1 = {ns[0], 1'b1};
         c0 = pm[p0] + PM_W'(hamming(dec_d_in, branch_out(p0, u)));
         c1 = pm[p1] + PM_W'(hamming(dec_d_in, branch_out(p1, u)));
         if (c1 < c0) begin
            pm_next[n]   = c1 - min_pm;
            surv_next[n] = {surv[p1][TB_DEPTH-2:0], u};
         end else begin
            pm_next[n]   = c0 - min_pm;
            surv_next[n] = {surv[p0][TB_DEPTH-2:0], u};
         end
      end
   end

   // Commit metrics and survivors per enabled symbol; emit the oldest bit of the best path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSTATES; i++) begin
            pm[i]   <= (i == 0) ? '0 : PM_W'(8);
            surv[i] <= '0;
         end
         dec_d_out <= 1'b0;
      end else if (dec_enable) begin
         for (int i = 0; i < NSTATES; i++) begin
            pm[i]   <= pm_next[i];
            surv[i] <= surv_next[i];
         end
         dec_d_out <= surv[best][TB_DEPTH-1];
      end
   end

endmodule

// File: tb/tb_viterbi_codec.sv
// Randomized loopback bench for viterbi_codec with an external channel register.
module tb_viterbi_codec;

   localparam int TB_DEPTH = 16;
   localparam int PM_W     = 8;
   localparam int FLUSH    = 18;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enc_enable_i = 1'b0;
   logic       enc_d_in = 1'b0;
   logic       enc_valid_o;
   logic [1:0] enc_d_out;
   logic       dec_enable;
   logic [1:0] dec_d_in;
   logic       dec_d_out;

   int n_checks = 0;
   int n_pass   = 0;
   int err_mode = 0;

   logic [1:0] chan_sym;
   logic       chan_v;
   int         chan_idx;

   logic [1:0] exp_enc;
   logic       exp_valid;
   logic       exp_dec;
   bit         dec_check;
   int         dec_n;
   bit         h1, h2;
   bit         sent[$];

   viterbi_codec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .enc_enable_i (enc_enable_i),
      .enc_d_in     (enc_d_in),
      .enc_valid_o  (enc_valid_o),
      .enc_d_out    (enc_d_out),
      .dec_enable   (dec_enable),
      .dec_d_in     (dec_d_in),
      .dec_d_out    (dec_d_out)
   );

   always #5 clk = ~clk;

   assign dec_d_in   = chan_sym;
   assign dec_enable = chan_v;

   // Error pattern applied to channel symbol idx for each scenario.
   function automatic logic [1:0] err_mask(input int mode, input int idx);
      if (mode == 1 && idx < 240 && ((idx % 16) == 7 || (idx % 16) == 8)) return 2'b01;
      if (mode == 2 && idx == 40) return 2'b11;
      return 2'b00;
   endfunction

   task automatic checkOutput(input string name, input logic [1:0] got, input logic [1:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, want, $time);
   endtask

   // Channel: one register between encoder and decoder, with error injection.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         chan_sym <= 2'b00;
         chan_v   <= 1'b0;
         chan_idx = 0;
      end else begin
         chan_sym <= enc_d_out ^ err_mask(err_mode, chan_idx);
         chan_v   <= enc_valid_o;
         if (enc_valid_o) chan_idx++;
      end
   end

   // Reference model: generator equations for the encoder, delayed bit stream for the decoder.
   initial forever begin
      int k;
      bit b;
      @(posedge clk or posedge rst);
      if (rst) begin
         exp_enc   = 2'b00;
         exp_valid = 1'b0;
         exp_dec   = 1'b0;
         dec_check = 1'b0;
         dec_n     = 0;
         h1        = 1'b0;
         h2        = 1'b0;
         sent.delete();
      end else begin
         if (dec_enable) begin
            dec_n++;
            k = dec_n - TB_DEPTH - 1;
            if (k >= 0 && k < sent.size()) begin
               exp_dec   = sent[k];
               dec_check = 1'b1;
            end else begin
               dec_check = 1'b0;
            end
         end
         if (enc_enable_i) begin
            b       = enc_d_in;
            exp_enc = {b ^ h1 ^ h2, b ^ h2};
            h2      = h1;
            h1      = b;
            sent.push_back(b);
         end
         exp_valid = enc_enable_i;
      end
   end

   // Compare DUT against the model on every falling edge outside reset.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         checkOutput("enc_valid", {1'b0, enc_valid_o}, {1'b0, exp_valid});
         checkOutput("enc_d_out", enc_d_out, exp_enc);
         if (dec_check) checkOutput("dec_d_out", {1'b0, dec_d_out}, {1'b0, exp_dec});
      end
   end

   // Asynchronous reset between clock edges; outputs must clear without a clock.
   task automatic resetDut();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_enc_d_out", enc_d_out, 2'b00);
      checkOutput("rst_enc_valid", {1'b0, enc_valid_o}, 2'b00);
      checkOutput("rst_dec_d_out", {1'b0, dec_d_out}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Stream nbits (random or zero) plus a zero flush, optionally pausing 5 cycles, then drain.
   task automatic applyStimulus(input int nbits, input int mode, input bit zeros, input int freeze_at);
      err_mode = mode;
      for (int i = 0; i < nbits + FLUSH; i++) begin
         @(negedge clk);
         if (i == freeze_at) begin
            enc_enable_i = 1'b0;
            repeat (5) @(negedge clk);
         end
         enc_enable_i = 1'b1;
         enc_d_in     = (i < nbits && !zeros) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      enc_enable_i = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [1:0] lit [6];
      bit         bits [6];
      lit  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
      bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      resetDut();

      // Hand-computed encoder sequence
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checkOutput("lit_enc_d_out", enc_d_out, lit[i-1]);
            checkOutput("lit_enc_valid", {1'b0, enc_valid_o}, 2'b01);
         end
         enc_enable_i = 1'b1;
         enc_d_in     = bits[i];
      end
      @(negedge clk);
      checkOutput("lit_enc_d_out", enc_d_out, lit[5]);
      enc_enable_i = 1'b0;
      @(negedge clk);
      checkOutput("lit_enc_valid_low", {1'b0, enc_valid_o}, 2'b00);
      checkOutput("lit_enc_hold", enc_d_out, lit[5]);

      // Error-free random loopback
      resetDut();
      applyStimulus(256, 0, 1'b0, -1);

      // Paired G1-bit errors every 16 symbols
      resetDut();
      applyStimulus(256, 1, 1'b0, -1);

      // All-zero stream with one symbol forced to 11
      resetDut();
      applyStimulus(120, 2, 1'b1, -1);
      checkOutput("zero_dec_d_out", {1'b0, dec_d_out}, 2'b00);

      // Pause mid-stream; decoding must resume without losing bits
      resetDut();
      applyStimulus(200, 0, 1'b0, 100);

      // Mid-stream reset after a run of ones, then a fresh stream
      resetDut();
      err_mode = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         enc_enable_i = 1'b1;
         enc_d_in     = (i < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      checkOutput("pre_rst_dec_d_out", {1'b0, dec_d_out}, 2'b01);
      resetDut();
      enc_enable_i = 1'b0;
      applyStimulus(150, 0, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/viterbi_codec.md
Name: viterbi_codec

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder plus hard-decision Viterbi decoder in one block.
- The encoder path feeds the channel model; the decoder path receives the possibly corrupted symbol pairs and recovers the original bit stream.
- The two paths share the clock and reset only. The channel (register plus error injection) is external.

Parameters:
- TB_DEPTH, 16, survivor (register-exchange) length in symbols; decoding latency in enabled symbols.
- PM_W, 8, path-metric width in bits (unsigned).

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enc_enable_i  in  1  encoder input-bit qualifier.
- enc_d_in  in  1  encoder information bit.
- enc_valid_o  out  1  encoder output-symbol qualifier.
- enc_d_out  out  2  encoded symbol: [1]=G0 (111), [0]=G1 (101).
- dec_enable  in  1  decoder input-symbol qualifier.
- dec_d_in  in  2  received symbol, same bit order as enc_d_out.
- dec_d_out  out  1  decoded information bit.

Behaviour:
- Reset (rst=1, async):
  - Encoder shift state = 00; enc_d_out = 00; enc_valid_o = 0.
  - Path metrics: state 0 = 0, states 1..3 = 8.
  - All survivor registers = 0; dec_d_out = 0.
  - Reset mid-stream discards all history; the first post-reset symbol is treated as starting from state 0.
- Encoder, with state s = {b[n-1], b[n-2]} and input u:
  - On clk with enc_enable_i=1: enc_d_out <= {u^s1^s0, u^s0}; s <= {u, s1}.
  - enc_valid_o <= enc_enable_i, so latency is 1 cycle.
  - On clk with enc_enable_i=0: s and enc_d_out hold; enc_valid_o <= 0.
- Trellis:
  - Next state ns = {u, s1}; the predecessors of ns = {u, x} are {x,0} and {x,1}.
  - Branch output = encoder output for (s, u).
- Branch metric = Hamming distance between dec_d_in and the branch output, range 0..2.
- ACS, on clk with dec_enable=1, for each ns:
  - Candidate metric = PM[pred] + BM.
  - Choose the smaller candidate. On a tie, choose the predecessor with s0=0.
  - New PM = chosen value − min(old PM[0..3]). Normalisation keeps metrics ≤ 12 and never underflows; no saturation is needed.
- Survivors (register exchange):
  - surv[ns] <= {surv[chosen pred][TB_DEPTH-2:0], u}.
  - Bit 0 is the newest decision; bit TB_DEPTH-1 is the oldest.
- Output:
  - On the same enabled edge, dec_d_out <= surv[best][TB_DEPTH-1].
  - best = state with minimum current (pre-update) PM; lowest index wins ties.
  - Bit k of the information stream appears on dec_d_out after the (k+TB_DEPTH+1)-th enabled decoder symbol.
  - Outputs before that are don't-care; they are 0 after reset.
- dec_enable=0: PM, survivors and dec_d_out hold.
- Error correction: free distance 5. Any ≤2 symbol-bit errors within 2*TB_DEPTH consecutive symbols, not in the last TB_DEPTH symbols before the bit is output, are corrected.
- Encoder and decoder paths are fully independent; simultaneous enables are legal.

Decomposition:
- Package viterbi_pkg holds:
  - K=3; NSTATES=4; generator constants G0=3'b111, G1=3'b101.
  - typedef sym_t logic [1:0]; typedef state_t logic [1:0].
  - A function branch_out(state_t s, logic u) returning sym_t, used by both encoder and decoder.
- One natural sub-module: conv_encoder_k3, which holds the encoder path.
- The ACS array and the register-exchange survivor memory stay in viterbi_codec.

Test Plan:
- Reset then enc_enable_i=1 with bits 1,0,1,1,0,0 → enc_d_out = 11,10,00,01,01,11, each 1 cycle after its bit; enc_valid_o high 1 cycle after enable.
- Loopback with one external register and no errors; 256 random bits followed by 18 zero bits → dec_d_out equals the input stream delayed by TB_DEPTH+1 decoder symbols, zero mismatches.
- Loopback with dec_d_in[0] inverted on 2 consecutive symbols every 16 symbols → decoded stream error-free.
- All-zero input with a single symbol forced to 11 → dec_d_out stays 0 throughout; PM[0] ≤ 2 at all times.
- dec_enable deasserted for 5 cycles mid-stream → dec_d_out and metrics frozen; decoding resumes with no bit loss.
- rst pulsed mid-stream → outputs go to 0 immediately without a clock edge; a fresh stream decodes correctly.
